// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the text VRAM arbiter.
// Cell layout: char in [6:0], colour in [27:16].
package vram_arbiter_pkg;

  localparam int VRAM_COLS   = 80;
  localparam int VRAM_ROWS   = 50;
  localparam int VRAM_DEPTH  = VRAM_COLS * VRAM_ROWS;
  localparam int VRAM_AW     = 12;
  localparam int VRAM_STARVE = 8;

  localparam int CHAR_LSB  = 0;
  localparam int CHAR_MSB  = 6;
  localparam int COLOR_LSB = 16;
  localparam int COLOR_MSB = 27;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef struct packed {
    owner_e own;
    logic   oor;
  } tag_t;

  localparam tag_t TAG_NONE = '{own: OWN_NONE, oor: 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_DONE   = 2'd2
  } cpu_st_e;

  function automatic logic [6:0] cell_char(input logic [31:0] w);
    return w[CHAR_MSB:CHAR_LSB];
  endfunction

  function automatic logic [11:0] cell_color(input logic [31:0] w);
    return w[COLOR_MSB:COLOR_LSB];
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// VGA fetch, CPU data and VRAM macro signals of the arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface vram_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [31:0]       vga_rdata;
  logic              vga_rvalid;
  logic              vga_miss;
  logic              cpu_req;
  logic              cpu_we;
  logic [3:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  vga_req, vga_addr,
    input  cpu_req, cpu_we, cpu_be,
    input  cpu_addr, cpu_wdata,
    input  ram_rdata,
    output vga_rdata, vga_rvalid, vga_miss,
    output cpu_rdata, cpu_ack,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vga_req, vga_addr,
    output cpu_req, cpu_we, cpu_be,
    output cpu_addr, cpu_wdata,
    output ram_rdata,
    input  vga_rdata, vga_rvalid, vga_miss,
    input  cpu_rdata, cpu_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter_tag_pipe.sv
// Two-stage owner tag pipe; stage 1 lines up with ram_rdata,
// stage 2 with the registered VGA result.
module vram_arbiter_tag_pipe
  import vram_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  tag_t   i_tag,
  output tag_t   o_s1,
  output owner_e o_own2
);

  tag_t   r_s1;
  owner_e r_own2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= TAG_NONE;
      r_own2 <= OWN_NONE;
    end else begin
      r_s1   <= i_tag;
      r_own2 <= r_s1.own;
    end
  end

  assign o_s1   = r_s1;
  assign o_own2 = r_own2;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: VGA fetch first, CPU in free
// cycles, with a starvation override for a waiting CPU.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = VRAM_AW,
  parameter int DEPTH        = VRAM_DEPTH,
  parameter int STARVE_LIMIT = VRAM_STARVE
)(
  input logic           clk,
  input logic           clrn,
  vram_arbiter_if.slave bus
);

  localparam int          CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  cpu_st_e          r_state;
  logic [CNT_W-1:0] r_starve;
  logic             r_cpu_ack;
  logic [31:0]      r_cpu_rdata;
  logic [31:0]      r_vga_rdata;

  logic   w_vga_in;
  logic   w_cpu_in;
  logic   w_cpu_pend;
  logic   w_starve;
  logic   w_g_vga;
  logic   w_g_cpu;
  tag_t   w_tag;
  tag_t   w_s1;
  owner_e w_own2;

  assign w_vga_in = 32'(bus.vga_addr) < DEPTH_U;
  assign w_cpu_in = 32'(bus.cpu_addr) < DEPTH_U;

  // Gating with clrn keeps the RAM port quiet while reset is held.
  assign w_cpu_pend = clrn && bus.cpu_req
                   && (r_state == ST_IDLE);
  assign w_starve = w_cpu_pend
                 && (r_starve == CNT_W'(STARVE_LIMIT));
  assign w_g_cpu = w_cpu_pend
                && (w_starve || !bus.vga_req);
  assign w_g_vga = clrn && bus.vga_req && !w_starve;

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    w_tag         = TAG_NONE;
    unique case (1'b1)
      w_g_vga: begin
        w_tag = '{own: OWN_VGA, oor: !w_vga_in};
        if (w_vga_in) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = bus.vga_addr;
        end
      end
      w_g_cpu: begin
        w_tag = '{own: OWN_CPU, oor: !w_cpu_in};
        if (w_cpu_in) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = bus.cpu_addr;
          if (bus.cpu_we) begin
            bus.ram_we    = bus.cpu_be;
            bus.ram_wdata = bus.cpu_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  vram_arbiter_tag_pipe u_tag (
    .clk    (clk),
    .rst_n  (clrn),
    .i_tag  (w_tag),
    .o_s1   (w_s1),
    .o_own2 (w_own2)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= ST_IDLE;
      r_starve    <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_vga_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      if (w_s1.own == OWN_VGA)
        r_vga_rdata <= w_s1.oor ? '0 : bus.ram_rdata;
      unique case (r_state)
        ST_IDLE: begin
          if (w_g_cpu) begin
            r_starve  <= '0;
            r_cpu_ack <= bus.cpu_we;
            r_state   <= bus.cpu_we ? ST_DONE
                                    : ST_RDWAIT;
          end else if (w_cpu_pend) begin
            r_starve <= r_starve + 1'b1;
          end
        end
        ST_RDWAIT: begin
          r_cpu_ack   <= 1'b1;
          r_cpu_rdata <= w_s1.oor ? '0 : bus.ram_rdata;
          r_state     <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vga_rvalid = (w_own2 == OWN_VGA);
  assign bus.vga_rdata  = r_vga_rdata;
  assign bus.vga_miss   = w_starve && bus.vga_req;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed literal cases followed by
// random traffic against a timestamp/queue reference model.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(12)) bus ();

  vram_arbiter dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 81) return 32'h0FFF0041;
    if (i == 5)  return 32'h0;
    return 32'h5A000000 ^ (i * 32'h00010003);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, act, exp);
    end
  endtask

  // VRAM macro: 1-cycle synchronous read, byte writes
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    bus.ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_en) begin
        bus.ram_rdata <= mem[bus.ram_addr];
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b])
            mem[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: grants from priority rules, results
  // scheduled as (cycle, data) events in queues.
  typedef struct { int cyc; logic [31:0] d; } vev_t;
  typedef struct { int cyc; bit rd; logic [31:0] d; } cev_t;
  vev_t vq[$];
  cev_t cq[$];
  logic [31:0] ref_mem [4096];

  initial begin
    int cyc, cpu_ok_at, starve;
    logic [31:0] held_vd;
    bit pend, st, gc, gv, e_rv, e_ack, in_r;
    logic e_en;
    logic [3:0] e_we;
    logic [11:0] e_ad;
    logic [31:0] e_wd, d;
    cyc = 0; cpu_ok_at = 0; starve = 0; held_vd = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!clrn) begin
        vq.delete(); cq.delete();
        starve = 0; cpu_ok_at = 0; held_vd = '0;
        chk("rst_en", bus.ram_en, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_wd", bus.ram_wdata, 0);
        chk("rst_miss", bus.vga_miss, 0);
        chk("rst_rv", bus.vga_rvalid, 0);
        chk("rst_vd", bus.vga_rdata, 0);
        chk("rst_ack", bus.cpu_ack, 0);
        chk("rst_cd", bus.cpu_rdata, 0);
      end else begin
        e_rv = 0;
        if (vq.size() > 0 && vq[0].cyc == cyc) begin
          e_rv = 1; held_vd = vq[0].d;
          void'(vq.pop_front());
        end
        chk("m_rvalid", bus.vga_rvalid, e_rv);
        chk("m_vrdata", bus.vga_rdata, held_vd);
        e_ack = 0;
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
          e_ack = 1;
          if (cq[0].rd) chk("m_crdata", bus.cpu_rdata, cq[0].d);
          void'(cq.pop_front());
        end
        chk("m_ack", bus.cpu_ack, e_ack);

        pend = bus.cpu_req && (cyc >= cpu_ok_at);
        st   = pend && (starve == 8);
        gc   = pend && (st || !bus.vga_req);
        gv   = bus.vga_req && !st;
        e_en = 0; e_we = 0; e_ad = 0; e_wd = 0;
        if (gv) begin
          in_r = bus.vga_addr < 12'd4000;
          d = in_r ? ref_mem[bus.vga_addr] : 32'h0;
          if (in_r) begin e_en = 1; e_ad = bus.vga_addr; end
          vq.push_back('{cyc + 2, d});
        end
        if (gc) begin
          in_r = bus.cpu_addr < 12'd4000;
          if (in_r) begin
            e_en = 1; e_ad = bus.cpu_addr;
            if (bus.cpu_we) begin
              e_we = bus.cpu_be; e_wd = bus.cpu_wdata;
            end
          end
        end
        chk("m_en", bus.ram_en, e_en);
        chk("m_we", bus.ram_we, e_we);
        chk("m_addr", bus.ram_addr, e_ad);
        chk("m_wdata", bus.ram_wdata, e_wd);
        chk("m_miss", bus.vga_miss, st && bus.vga_req);
        if (gc) begin
          starve = 0;
          if (bus.cpu_we) begin
            if (in_r)
              for (int b = 0; b < 4; b++)
                if (bus.cpu_be[b])
                  ref_mem[bus.cpu_addr][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
            cq.push_back('{cyc + 1, 1'b0, 32'h0});
            cpu_ok_at = cyc + 2;
          end else begin
            d = in_r ? ref_mem[bus.cpu_addr] : 32'h0;
            cq.push_back('{cyc + 2, 1'b1, d});
            cpu_ok_at = cyc + 3;
          end
        end else if (pend) begin
          starve++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  function automatic logic [11:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 12'(4000 + $urandom_range(0, 95));
    if (r == 1) return 12'($urandom_range(0, 3999));
    return 12'($urandom_range(0, 31));
  endfunction

  task automatic cpu_set(input logic we, input logic [3:0] be,
                         input logic [11:0] a,
                         input logic [31:0] wd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_be = be;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
  endtask

  initial begin
    logic ackd;
    int misses, pct;
    clrn = 1'b0;
    bus.vga_req = 0; bus.vga_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_be = '0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) tick();
    clrn = 1'b1;

    // VGA fetch of cell 81
    tick(); bus.vga_req = 1; bus.vga_addr = 12'd81;
    neg(); chk("t2_en", bus.ram_en, 1);
    chk("t2_addr", bus.ram_addr, 81);
    tick(); bus.vga_req = 0;
    neg(); chk("t2_rv_early", bus.vga_rvalid, 0);
    tick(); neg();
    chk("t2_rv", bus.vga_rvalid, 1);
    chk("t2_rd", bus.vga_rdata, 32'h0FFF0041);

    // byte-enabled write then read back
    tick(); cpu_set(1, 4'b0011, 12'd5, 32'hAAAA5555);
    neg(); chk("t3_we", bus.ram_we, 4'b0011);
    chk("t3_ack0", bus.cpu_ack, 0);
    tick(); neg(); chk("t3_wack", bus.cpu_ack, 1);
    tick(); bus.cpu_req = 0;
    tick(); cpu_set(0, 4'b0000, 12'd5, 32'h0);
    neg(); chk("t3_ren", bus.ram_en, 1);
    chk("t3_rwe", bus.ram_we, 0);
    tick(); neg(); chk("t3_rack0", bus.cpu_ack, 0);
    tick(); neg(); chk("t3_rack", bus.cpu_ack, 1);
    chk("t3_rdata", bus.cpu_rdata, 32'h00005555);
    tick(); bus.cpu_req = 0;

    // simultaneous VGA and CPU read
    tick(); bus.vga_req = 1; bus.vga_addr = 12'd10;
    cpu_set(0, 4'b0000, 12'd20, 32'h0);
    neg(); chk("t4_a0", bus.ram_addr, 10);
    tick(); bus.vga_req = 0;
    neg(); chk("t4_a1", bus.ram_addr, 20);
    chk("t4_en1", bus.ram_en, 1);
    tick(); neg(); chk("t4_rv", bus.vga_rvalid, 1);
    chk("t4_ack0", bus.cpu_ack, 0);
    tick(); neg(); chk("t4_ack", bus.cpu_ack, 1);
    chk("t4_rdata", bus.cpu_rdata, init_word(20));
    tick(); bus.cpu_req = 0;

    // starvation override, twice to show the counter restarts
    tick(); bus.vga_req = 1; bus.vga_addr = 12'd30;
    cpu_set(1, 4'hF, 12'd7, 32'h12345678);
    misses = 0;
    for (int i = 1; i <= 20; i++) begin
      neg();
      if (bus.vga_miss) misses++;
      if (i == 9 || i == 20) begin
        chk("t5_we", bus.ram_we, 4'hF);
        chk("t5_miss", bus.vga_miss, 1);
        chk("t5_addr", bus.ram_addr, (i == 9) ? 7 : 8);
      end
      ackd = bus.cpu_ack;
      tick();
      if (ackd) bus.cpu_req = 0;
      if (i == 11) cpu_set(1, 4'hF, 12'd8, 32'h0BADF00D);
    end
    chk("t5_misses", misses, 2);
    bus.vga_req = 0;
    neg(); chk("t5_ack2", bus.cpu_ack, 1);
    tick(); bus.cpu_req = 0;

    // out-of-range CPU accesses
    tick(); cpu_set(1, 4'hF, 12'd4000, 32'hFFFFFFFF);
    neg(); chk("t6_en", bus.ram_en, 0);
    chk("t6_we", bus.ram_we, 0);
    tick(); neg(); chk("t6_wack", bus.cpu_ack, 1);
    chk("t6_we1", bus.ram_we, 0);
    tick(); bus.cpu_req = 0;
    tick(); cpu_set(0, 4'h0, 12'd4000, 32'h0);
    neg(); chk("t6_ren", bus.ram_en, 0);
    tick(); neg();
    tick(); neg(); chk("t6_rack", bus.cpu_ack, 1);
    chk("t6_rd", bus.cpu_rdata, 0);
    tick(); bus.cpu_req = 0;

    // reset while a CPU read sits in RDWAIT
    tick(); cpu_set(0, 4'h0, 12'd3, 32'h0);
    neg(); chk("t6_g", bus.ram_en, 1);
    tick(); clrn = 0; bus.cpu_req = 0;
    bus.vga_req = 1; bus.vga_addr = 12'd40;
    neg(); chk("t1_en", bus.ram_en, 0);
    chk("t1_ack", bus.cpu_ack, 0);
    chk("t1_vd", bus.vga_rdata, 0);
    chk("t1_miss", bus.vga_miss, 0);
    tick(); clrn = 1; bus.vga_req = 0;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("t1_noack", bus.cpu_ack, 0);
      chk("t1_norv", bus.vga_rvalid, 0);
      tick();
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      neg(); ackd = bus.cpu_ack;
      tick();
      if (!clrn) clrn = 1;
      else if ($urandom_range(0, 399) == 0) begin
        clrn = 0; bus.cpu_req = 0;
      end
      pct = (i < 1000) ? 30 : (i < 2000) ? 100 : 70;
      bus.vga_req  = ($urandom_range(0, 99) < pct);
      bus.vga_addr = rand_addr();
      if (bus.cpu_req && ackd)
        bus.cpu_req = 0;
      else if (!bus.cpu_req && clrn
               && $urandom_range(0, 99) < 40)
        cpu_set(1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)),
                rand_addr(), $urandom);
    end
    clrn = 1; bus.vga_req = 0;
    repeat (12) begin
      neg(); ackd = bus.cpu_ack;
      tick();
      if (ackd) bus.cpu_req = 0;
    end
    chk("drain_vq", vq.size(), 0);
    chk("drain_cq", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
